// File: rtl/axis_tmr_vote_datapath.sv
`timescale 1ns/1ps
// Triple-redundant AXI-Stream datapath: fan-out to three lanes, three replica registers, 2-of-3 voter.
// Define TMR_FAULT_INJECT_EN to add fault_mask/fault_lane inputs and the mismatch_count output.
module axis_tmr_vote_datapath #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
`ifdef TMR_FAULT_INJECT_EN
  ,
  input  logic [DATA_WIDTH-1:0] fault_mask,
  input  logic [1:0]            fault_lane,
  output logic [15:0]           mismatch_count
`endif
);

  logic [2:0]            lane_ready;
  logic [2:0]            rep_valid;
  logic [2:0]            rep_last;
  logic [DATA_WIDTH-1:0] rep_data [3];
  logic                  s_accept;
  logic                  fire;
  logic                  out_ready;

  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

  // A beat enters all three lanes together or not at all.
  assign s_axis_tready = &lane_ready;
  assign s_accept      = s_axis_tvalid & s_axis_tready;
  assign out_ready     = !out_valid_q | m_axis_tready;
  assign fire          = (&rep_valid) & out_ready;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
      logic                  lane_valid_q, lane_valid_d;
      logic                  lane_last_q, lane_last_d;
      logic [DATA_WIDTH-1:0] lane_data_q, lane_data_d;
      logic                  rep_valid_q, rep_valid_d;
      logic                  rep_last_q, rep_last_d;
      logic [DATA_WIDTH-1:0] rep_data_q, rep_data_d;
      logic                  rep_ready;
`ifdef TMR_FAULT_INJECT_EN
      localparam logic [1:0] LANE_ID = 2'(gi);
`endif

      assign rep_ready      = !rep_valid_q | fire;
      assign lane_ready[gi] = !lane_valid_q | rep_ready;

      always_comb begin
        lane_valid_d = lane_valid_q;
        lane_last_d  = lane_last_q;
        lane_data_d  = lane_data_q;
        rep_valid_d  = rep_valid_q;
        rep_last_d   = rep_last_q;
        rep_data_d   = rep_data_q;
        if (lane_valid_q && rep_ready) begin
          rep_valid_d  = 1'b1;
          rep_last_d   = lane_last_q;
`ifdef TMR_FAULT_INJECT_EN
          rep_data_d   = lane_data_q ^ ((fault_lane == LANE_ID) ? fault_mask : '0);
`else
          rep_data_d   = lane_data_q;
`endif
          lane_valid_d = 1'b0;
        end else if (fire) begin
          rep_valid_d = 1'b0;
        end
        if (s_accept) begin
          lane_valid_d = 1'b1;
          lane_last_d  = s_axis_tlast;
          lane_data_d  = s_axis_tdata;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          lane_valid_q <= 1'b0;
          lane_last_q  <= 1'b0;
          lane_data_q  <= '0;
          rep_valid_q  <= 1'b0;
          rep_last_q   <= 1'b0;
          rep_data_q   <= '0;
        end else begin
          lane_valid_q <= lane_valid_d;
          lane_last_q  <= lane_last_d;
          lane_data_q  <= lane_data_d;
          rep_valid_q  <= rep_valid_d;
          rep_last_q   <= rep_last_d;
          rep_data_q   <= rep_data_d;
        end
      end

      assign rep_valid[gi] = rep_valid_q;
      assign rep_last[gi]  = rep_last_q;
      assign rep_data[gi]  = rep_data_q;
    end
  endgenerate

  always_comb begin
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    if (fire) begin
      out_valid_d = 1'b1;
      out_data_d  = (rep_data[0] & rep_data[1]) | (rep_data[0] & rep_data[2]) |
                    (rep_data[1] & rep_data[2]);
      out_last_d  = (rep_last[0] & rep_last[1]) | (rep_last[0] & rep_last[2]) |
                    (rep_last[1] & rep_last[2]);
    end else if (m_axis_tready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tlast  = out_last_q;

`ifdef TMR_FAULT_INJECT_EN
  logic [15:0] mismatch_count_q, mismatch_count_d;

  always_comb begin
    mismatch_count_d = mismatch_count_q;
    if (fire && !((rep_data[0] == rep_data[1]) && (rep_data[1] == rep_data[2])) &&
        (mismatch_count_q != 16'hFFFF)) begin
      mismatch_count_d = mismatch_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_count_q <= '0;
    end else begin
      mismatch_count_q <= mismatch_count_d;
    end
  end

  assign mismatch_count = mismatch_count_q;
`endif

endmodule

// File: tb/tb_axis_tmr_vote_datapath.sv
`timescale 1ns/1ps
// Bench for axis_tmr_vote_datapath: cycle table for directed cases, hand sequences for reset/fault,
// and a randomized stream checked against an in-order queue model.
module tb_axis_tmr_vote_datapath;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] s_axis_tdata = '0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tready;
  logic         s_axis_tlast = 1'b0;
  logic [W-1:0] m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready = 1'b1;
  logic         m_axis_tlast;
`ifdef TMR_FAULT_INJECT_EN
  logic [W-1:0] fault_mask = '0;
  logic [1:0]   fault_lane = 2'd3;
  logic [15:0]  mismatch_count;
`endif

  always #5 clk = ~clk;

  axis_tmr_vote_datapath #(.DATA_WIDTH(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
`ifdef TMR_FAULT_INJECT_EN
    ,
    .fault_mask    (fault_mask),
    .fault_lane    (fault_lane),
    .mismatch_count(mismatch_count)
`endif
  );

  // One row per clock cycle: inputs driven after the edge, outputs checked at the following negedge.
  typedef struct {
    logic         sv;
    logic [W-1:0] sd;
    logic         sl;
    logic         mr;
    logic         exp_sr;
    logic         exp_mv;
    logic [W-1:0] exp_md;
    logic         exp_ml;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic sv, input logic [W-1:0] sd, input logic sl,
                              input logic mr, input logic esr, input logic emv,
                              input logic [W-1:0] emd, input logic eml);
    vec_t v;
    v.sv = sv; v.sd = sd; v.sl = sl; v.mr = mr;
    v.exp_sr = esr; v.exp_mv = emv; v.exp_md = emd; v.exp_ml = eml;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32:0] model_q[$];
    logic [32:0] exp_beat;
    int          sent;
    int          received;
    int          guard;
    bit          accepted;
    bit          seen;

    // Test 1: single-cycle pulse, output exactly once two edges after acceptance.
    vecs.push_back(mk(1, 32'hFFFFFFFF, 1, 1, 1, 0, 32'h0, 0));
    vecs.push_back(mk(0, 32'h0, 0, 1, 1, 0, 32'h0, 0));
    vecs.push_back(mk(0, 32'h0, 0, 1, 1, 0, 32'h0, 0));
    vecs.push_back(mk(0, 32'h0, 0, 1, 1, 1, 32'hFFFFFFFF, 1));
    vecs.push_back(mk(0, 32'h0, 0, 1, 1, 0, 32'h0, 0));
    vecs.push_back(mk(0, 32'h0, 0, 1, 1, 0, 32'h0, 0));
    // Test 2: back-to-back beats, full throughput.
    vecs.push_back(mk(1, 32'd1, 0, 1, 1, 0, 32'h0, 0));
    vecs.push_back(mk(1, 32'd2, 0, 1, 1, 0, 32'h0, 0));
    vecs.push_back(mk(1, 32'd3, 0, 1, 1, 0, 32'h0, 0));
    vecs.push_back(mk(1, 32'd4, 1, 1, 1, 1, 32'd1, 0));
    vecs.push_back(mk(0, 32'h0, 0, 1, 1, 1, 32'd2, 0));
    vecs.push_back(mk(0, 32'h0, 0, 1, 1, 1, 32'd3, 0));
    vecs.push_back(mk(0, 32'h0, 0, 1, 1, 1, 32'd4, 1));
    vecs.push_back(mk(0, 32'h0, 0, 1, 1, 0, 32'h0, 0));
    // Test 3: downstream stalled, ready drops after three accepts, then drains in order.
    vecs.push_back(mk(1, 32'd11, 0, 0, 1, 0, 32'h0, 0));
    vecs.push_back(mk(1, 32'd12, 0, 0, 1, 0, 32'h0, 0));
    vecs.push_back(mk(1, 32'd13, 0, 0, 1, 0, 32'h0, 0));
    vecs.push_back(mk(1, 32'd14, 0, 0, 0, 1, 32'd11, 0));
    vecs.push_back(mk(1, 32'd14, 0, 0, 0, 1, 32'd11, 0));
    vecs.push_back(mk(1, 32'd14, 0, 1, 1, 1, 32'd11, 0));
    vecs.push_back(mk(1, 32'd15, 0, 1, 1, 1, 32'd12, 0));
    vecs.push_back(mk(1, 32'd16, 1, 1, 1, 1, 32'd13, 0));
    vecs.push_back(mk(0, 32'h0, 0, 1, 1, 1, 32'd14, 0));
    vecs.push_back(mk(0, 32'h0, 0, 1, 1, 1, 32'd15, 0));
    vecs.push_back(mk(0, 32'h0, 0, 1, 1, 1, 32'd16, 1));
    vecs.push_back(mk(0, 32'h0, 0, 1, 1, 0, 32'h0, 0));

    // Reset state.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset m_axis_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("reset m_axis_tdata", m_axis_tdata, 32'd0);
    chk("reset m_axis_tlast", 32'(m_axis_tlast), 32'd0);
    chk("reset s_axis_tready", 32'(s_axis_tready), 32'd1);
    tick();
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      s_axis_tvalid = vecs[i].sv;
      s_axis_tdata  = vecs[i].sd;
      s_axis_tlast  = vecs[i].sl;
      m_axis_tready = vecs[i].mr;
      @(negedge clk);
      $display("row %0d: s_ready=%b m_valid=%b m_data=%h m_last=%b", i, s_axis_tready,
               m_axis_tvalid, m_axis_tdata, m_axis_tlast);
      chk($sformatf("row%0d s_axis_tready", i), 32'(s_axis_tready), 32'(vecs[i].exp_sr));
      chk($sformatf("row%0d m_axis_tvalid", i), 32'(m_axis_tvalid), 32'(vecs[i].exp_mv));
      if (vecs[i].exp_mv) begin
        chk($sformatf("row%0d m_axis_tdata", i), m_axis_tdata, vecs[i].exp_md);
        chk($sformatf("row%0d m_axis_tlast", i), 32'(m_axis_tlast), 32'(vecs[i].exp_ml));
      end
      tick();
    end

    // Test 4: reset with two beats in flight discards them immediately.
    m_axis_tready = 1'b1;
    s_axis_tvalid = 1'b1; s_axis_tdata = 32'h21; s_axis_tlast = 1'b0;
    tick();
    s_axis_tdata = 32'h22;
    tick();
    s_axis_tvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    $display("mid-stream reset: m_valid=%b m_data=%h s_ready=%b", m_axis_tvalid, m_axis_tdata,
             s_axis_tready);
    chk("midreset m_axis_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("midreset m_axis_tdata", m_axis_tdata, 32'd0);
    chk("midreset s_axis_tready", 32'(s_axis_tready), 32'd1);
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (m_axis_tvalid) seen = 1'b1;
      tick();
    end
    chk("postreset stale beat", 32'(seen), 32'd0);

`ifdef TMR_FAULT_INJECT_EN
    // Test 5: a fault on one replica is outvoted and counted; no fault leaves the count alone.
    fault_lane = 2'd1; fault_mask = 32'h0000FFFF;
    s_axis_tvalid = 1'b1; s_axis_tdata = 32'hA5A5A5A5; s_axis_tlast = 1'b0;
    tick();
    s_axis_tvalid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6 && !seen; c++) begin
      @(negedge clk);
      if (m_axis_tvalid) begin
        seen = 1'b1;
        $display("fault beat: data=%h count=%0d", m_axis_tdata, mismatch_count);
        chk("fault voted data", m_axis_tdata, 32'hA5A5A5A5);
        chk("fault mismatch_count", 32'(mismatch_count), 32'd1);
      end
      tick();
    end
    chk("fault beat seen", 32'(seen), 32'd1);
    fault_lane = 2'd3;
    s_axis_tvalid = 1'b1;
    tick();
    s_axis_tvalid = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    chk("nofault mismatch_count", 32'(mismatch_count), 32'd1);
    tick();
`endif

    // Test 6: random valid/ready against an in-order reference queue.
    sent = 0; received = 0; guard = 0; accepted = 1'b1;
    s_axis_tvalid = 1'b0;
    while (received < 1000 && guard < 20000) begin
      guard++;
      if (!s_axis_tvalid || accepted) begin
        if (sent < 1000 && ($urandom % 4) != 0) begin
          s_axis_tvalid = 1'b1;
          s_axis_tdata  = $urandom;
          s_axis_tlast  = (($urandom % 8) == 0);
        end else begin
          s_axis_tvalid = 1'b0;
        end
      end
      m_axis_tready = (($urandom % 3) != 0);
      @(negedge clk);
      accepted = s_axis_tvalid && s_axis_tready;
      if (accepted) begin
        model_q.push_back({s_axis_tlast, s_axis_tdata});
        sent++;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (model_q.size() == 0) begin
          chk("random unexpected beat", 32'd1, 32'd0);
        end else begin
          exp_beat = model_q.pop_front();
          $display("beat %0d: data=%h last=%b", received, m_axis_tdata, m_axis_tlast);
          chk($sformatf("random beat%0d tdata", received), m_axis_tdata, exp_beat[31:0]);
          chk($sformatf("random beat%0d tlast", received), 32'(m_axis_tlast), 32'(exp_beat[32]));
        end
        received++;
      end
      tick();
    end
    chk("random beats received", 32'(received), 32'd1000);
    chk("random model drained", 32'(model_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
